// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bundle: one valid/ready handshake plus destination and data per requester.
interface regfile_wr_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int AW      = 3
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0][AW-1:0]    req_addr_i;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_data_i;

    modport master (
        output req_valid_i,
        output req_addr_i,
        output req_data_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_addr_i,
        input  req_data_i,
        output req_ready_o
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single regfile write port, with a registered write
// command and a per-register pending-write scoreboard for issue stalls.
module regfile_wr_arbiter #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int NUM_REQ  = 2,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    regfile_wr_arbiter_if.slave  rq,
    input  logic                 rsv_en_i,
    input  logic [AW-1:0]        rsv_addr_i,
    input  logic                 flush_i,
    output logic [DEPTH-1:0]     busy_o,
    output logic                 rf_wr_en_o,
    output logic [AW-1:0]        rf_wr_addr_o,
    output logic [WIDTH-1:0]     rf_wr_data_o
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_next;
    logic [PW-1:0]      gidx;
    logic               gvld;
    logic [NUM_REQ-1:0] grant;
    logic [AW-1:0]      gaddr;
    logic [WIDTH-1:0]   gdata;
    logic [DEPTH-1:0]   busy_q;
    logic [DEPTH-1:0]   busy_next;
    logic               wr_en_p1;
    logic [AW-1:0]      wr_addr_p1;
    logic [WIDTH-1:0]   wr_data_p1;

    // Search upward from the pointer, wrapping; flush and reset suppress any grant.
    always_comb begin
        int idx;
        idx   = 0;
        gidx  = '0;
        gvld  = 1'b0;
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gvld && rq.req_valid_i[idx]) begin
                gvld = 1'b1;
                gidx = PW'(idx);
            end
        end
        if (flush_i || !rst_ni) gvld = 1'b0;
        if (gvld) grant[gidx] = 1'b1;
    end

    assign rq.req_ready_o = grant;
    assign gaddr    = rq.req_addr_i[gidx];
    assign gdata    = rq.req_data_i[gidx];
    assign ptr_next = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

    // Clear first so a same-edge reservation of the granted register wins.
    always_comb begin
        busy_next = busy_q;
        if (gvld) busy_next[gaddr] = 1'b0;
        if (rsv_en_i && !(ZERO_REG && rsv_addr_i == '0)) busy_next[rsv_addr_i] = 1'b1;
        if (ZERO_REG) busy_next[0] = 1'b0;
    end

    // Stage p1: registered write command and scoreboard state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            busy_q     <= '0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else if (flush_i) begin
            ptr_q    <= '0;
            busy_q   <= '0;
            wr_en_p1 <= 1'b0;
        end else begin
            busy_q   <= busy_next;
            wr_en_p1 <= gvld && !(ZERO_REG && gaddr == '0);
            if (gvld) begin
                ptr_q      <= ptr_next;
                wr_addr_p1 <= gaddr;
                wr_data_p1 <= gdata;
            end
        end
    end

    assign busy_o       = busy_q;
    assign rf_wr_en_o   = wr_en_p1;
    assign rf_wr_addr_o = wr_addr_p1;
    assign rf_wr_data_o = wr_data_p1;
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port between NUM_REQ writeback sources (e.g. ALU, load unit) using round-robin arbitration and a valid/ready handshake. Drives a registered write command into the regfile write port. Also holds a pending-write scoreboard (busy bit per register) so issue logic can stall on destinations not yet written. Sits between the writeback sources and the regfile.

Parameters:
WIDTH, 32, data width; must match regfile WIDTH
DEPTH, 8, number of registers; AW = $clog2(DEPTH)
NUM_REQ, 2, number of writeback requesters (>=2)
ZERO_REG, 1, 1 = register 0 hardwired to zero; writes and reservations to it are discarded

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  NUM_REQ  requester i has a write pending
req_ready_o  out  NUM_REQ  requester i granted this cycle; one-hot or zero
req_addr_i  in  NUM_REQ x AW  destination register per requester
req_data_i  in  NUM_REQ x WIDTH  write data per requester
rsv_en_i  in  1  reserve a destination (mark busy)
rsv_addr_i  in  AW  register to reserve
flush_i  in  1  synchronous flush of scoreboard and pending output
busy_o  out  DEPTH  scoreboard bitmap, bit r = write to r pending
rf_wr_en_o  out  1  to regfile wr_en_i
rf_wr_addr_o  out  AW  to regfile wr_addr_i
rf_wr_data_o  out  WIDTH  to regfile wr_data_i

Behaviour:
- Reset (rst_ni low, async): rf_wr_en_o=0, rf_wr_addr_o=0, rf_wr_data_o=0, busy_o=0, round-robin pointer=0. req_ready_o=0 while in reset.
- Arbitration (combinational): search req_valid_i from pointer upward, wrapping mod NUM_REQ; first valid index g gets req_ready_o[g]=1. No valid -> req_ready_o=0. At most one grant per cycle; regfile never backpressures.
- Transfer occurs on the edge where valid && ready. Requester must hold addr/data stable while valid and not ready.
- Pointer: on a transfer by g, pointer <= (g+1) mod NUM_REQ; unchanged otherwise.
- Output stage: on the transfer edge, rf_wr_addr_o/rf_wr_data_o <= granted addr/data; rf_wr_en_o <= 1 unless (ZERO_REG && addr==0), then 0. Latency: grant in cycle N -> rf_wr_en_o high during cycle N+1; regfile commits at the end of N+1. No transfer -> rf_wr_en_o <= 0; addr/data hold previous values.
- Zero-register write: still accepted (ready=1, pointer advances) but produces no rf_wr_en_o pulse.
- Scoreboard set: rsv_en_i on an edge sets busy[rsv_addr_i]. With ZERO_REG, a reserve of 0 is ignored; busy_o[0] is constant 0.
- Scoreboard clear: on the transfer edge, busy[granted addr] <= 0. During cycle N+1, busy=0 and rf_wr_en_o=1; regfile write-through gives readers the correct value.
- Same edge set and clear of the same register: set wins (busy=1, new reservation). Set and clear of different registers both apply.
- Clearing a register that is not busy is legal and leaves it 0.
- flush_i (sampled on edge, priority over everything): busy <= 0, rf_wr_en_o <= 0, pointer <= 0. req_ready_o forced to 0 during the flush cycle, so no transfer occurs. rsv_en_i in the same cycle is ignored.
- Async reset mid-transfer drops the transfer. Outputs return to reset values immediately.

Test Plan:
- Reset: hold rst_ni=0 for 5 cycles with req_valid_i=2'b11 -> req_ready_o=0, rf_wr_en_o=0, busy_o=0. Release -> first grant goes to requester 0.
- Round-robin: both valid continuously, req0 {addr 1, 0x64} / req1 {addr 2, 0xC8} -> grants alternate 0,1,0,1. rf_wr_en_o high one cycle after each grant with matching addr/data; regfile reg1=0x64, reg2=0xC8.
- Zero register: req0 writes addr 0, data 0xDEADBEEF -> ready=1 and pointer advances to 1. rf_wr_en_o stays 0; regfile reg0 reads 0.
- Scoreboard: rsv addr 3 -> busy_o=8'h08 next cycle. req1 writes addr 3, 0x12345678 -> busy_o=0 in the cycle rf_wr_en_o=1, and a regfile read of 3 returns 0x12345678 in that same cycle via write-through.
- Set/clear collision: rsv addr 5 while addr 5 is being granted -> busy_o[5]=1 afterward. Simultaneous rsv 4 and grant of addr 6 (busy[6]=1 before) -> busy_o=8'h10.
- Flush: busy_o=8'hFE with both requesters valid, assert flush_i one cycle -> req_ready_o=0 that cycle. Next cycle busy_o=0, rf_wr_en_o=0, and the next grant goes to requester 0.
